// File: rtl/adv7513_cfg_sequencer_if.sv
// Request/response signals between the ADV7513 config sequencer and the I2C master.
// The sequencer drives the write request; the I2C master returns done/fail from its slow clock domain.
interface adv7513_cfg_sequencer_if;
   logic       i2c_start;
   logic [6:0] i2c_slave_address;
   logic [7:0] i2c_byte0;
   logic [7:0] i2c_byte1;
   logic [2:0] i2c_byte_num;
   logic       i2c_done;
   logic       i2c_fail;

   modport master (
      output i2c_start, i2c_slave_address, i2c_byte0, i2c_byte1, i2c_byte_num,
      input  i2c_done, i2c_fail
   );

   modport slave (
      input  i2c_start, i2c_slave_address, i2c_byte0, i2c_byte1, i2c_byte_num,
      output i2c_done, i2c_fail
   );
endinterface

// File: rtl/adv7513_cfg_sequencer.sv
// ADV7513 boot-time register writer: walks the LUT one I2C write at a time, with retry, timeout and hot-plug rerun.
// All outputs registered; i2c_start is held as a level until the I2C master resolves or the timeout expires.
module adv7513_cfg_sequencer #(
   parameter int         NUM_REGS    = 31,
   parameter logic [6:0] SLAVE_ADDR  = 7'h72,
   parameter int         POWERUP_CYC = 2_500_000,
   parameter int         GAP_CYC     = 5_000,
   parameter int         TIMEOUT_CYC = 500_000,
   parameter int         MAX_RETRIES = 3,
   parameter bit         HPD_REINIT  = 1'b1
) (
   input  logic                    clk_50,
   input  logic                    reset_al,
   input  logic                    hdmi_int,
   input  logic [15:0]             lut_data,
   output logic [5:0]              lut_index,
   output logic                    config_done,
   output logic                    config_error,
   output logic [1:0]              retry_count,
   adv7513_cfg_sequencer_if.master i2c
);
   localparam int CNT_A   = (POWERUP_CYC > GAP_CYC) ? POWERUP_CYC : GAP_CYC;
   localparam int CNT_MAX = (CNT_A > TIMEOUT_CYC) ? CNT_A : TIMEOUT_CYC;
   localparam int TW      = $clog2(CNT_MAX + 1);

   localparam logic [TW-1:0] PWR_LAST = TW'(POWERUP_CYC - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [5:0]    IDX_LAST = 6'(NUM_REGS - 1);
   localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

   typedef enum logic [3:0] {
      S_PWRUP, S_LOAD, S_START, S_WAIT, S_OK, S_FAIL, S_GAP, S_DONE, S_ERR
   } state_t;

   state_t        state, state_next, gap_ret;
   logic [TW-1:0] timer;
   logic [2:0]    done_sr, fail_sr, hpd_sr;
   logic          start_q;
   logic [7:0]    byte0_q, byte1_q;

   // sr[1] is the synchronised level, sr[2] its previous value for edge detection
   wire done_evt = done_sr[1] & ~done_sr[2];
   wire fail_evt = fail_sr[1] & ~fail_sr[2];
   wire fail_s   = fail_sr[1];
   wire hpd_evt  = hpd_sr[1] & ~hpd_sr[2];

   assign i2c.i2c_start         = start_q;
   assign i2c.i2c_byte0         = byte0_q;
   assign i2c.i2c_byte1         = byte1_q;
   assign i2c.i2c_slave_address = SLAVE_ADDR;
   assign i2c.i2c_byte_num      = 3'd2;

   always_comb begin
      state_next = state;
      case (state)
         S_PWRUP: if (timer == PWR_LAST) state_next = S_LOAD;
         S_LOAD:  state_next = S_START;
         S_START: state_next = S_WAIT;
         S_WAIT: begin
            if (fail_evt || (done_evt && fail_s)) state_next = S_FAIL;
            else if (done_evt)                    state_next = S_OK;
            else if (timer == TO_LAST)            state_next = S_FAIL;
         end
         S_OK:    state_next = S_GAP;
         S_FAIL:  state_next = (retry_count < RETRY_MAX) ? S_GAP : S_ERR;
         S_GAP:   if (timer == GAP_LAST) state_next = gap_ret;
         S_DONE:  if (HPD_REINIT && hpd_evt) state_next = S_PWRUP;
         S_ERR:   state_next = S_ERR;
         default: state_next = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk_50) begin
      if (!reset_al) begin
         state        <= S_PWRUP;
         gap_ret      <= S_LOAD;
         timer        <= '0;
         lut_index    <= '0;
         retry_count  <= '0;
         config_done  <= 1'b0;
         config_error <= 1'b0;
         start_q      <= 1'b0;
         byte0_q      <= '0;
         byte1_q      <= '0;
         done_sr      <= '0;
         fail_sr      <= '0;
         hpd_sr       <= '0;
      end else begin
         state   <= state_next;
         done_sr <= {done_sr[1:0], i2c.i2c_done};
         fail_sr <= {fail_sr[1:0], i2c.i2c_fail};
         hpd_sr  <= {hpd_sr[1:0], hdmi_int};

         // One shared timer: restarts on every state change, only runs in timed states
         if (state_next != state)
            timer <= '0;
         else if (state == S_PWRUP || state == S_GAP || state == S_WAIT)
            timer <= timer + 1'b1;

         start_q     <= (state_next == S_WAIT);
         config_done <= (state_next == S_DONE);

         case (state)
            S_LOAD: begin
               byte0_q <= lut_data[15:8];
               byte1_q <= lut_data[7:0];
            end
            S_OK: begin
               retry_count <= '0;
               if (lut_index == IDX_LAST) begin
                  gap_ret <= S_DONE;
               end else begin
                  gap_ret   <= S_LOAD;
                  lut_index <= lut_index + 6'd1;
               end
            end
            S_FAIL: begin
               gap_ret <= S_LOAD;
               if (retry_count < RETRY_MAX) retry_count  <= retry_count + 2'd1;
               else                         config_error <= 1'b1;
            end
            S_DONE: begin
               if (state_next == S_PWRUP) begin
                  lut_index   <= '0;
                  retry_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_adv7513_cfg_sequencer.sv
// Randomised bench for the ADV7513 config sequencer: behavioural I2C responder plus an attempt-list reference model.
module tb_adv7513_cfg_sequencer;
   localparam int N  = 31;
   localparam int P  = 60;
   localparam int G  = 6;
   localparam int T  = 40;
   localparam int MR = 3;

   logic        clk_50 = 1'b0;
   logic        reset_al;
   logic        hdmi_int;
   logic [15:0] lut_data;
   logic [5:0]  lut_index;
   logic        config_done, config_error;
   logic [1:0]  retry_count;

   adv7513_cfg_sequencer_if i2c_bus();

   adv7513_cfg_sequencer #(
      .NUM_REGS(N), .SLAVE_ADDR(7'h72), .POWERUP_CYC(P), .GAP_CYC(G),
      .TIMEOUT_CYC(T), .MAX_RETRIES(MR), .HPD_REINIT(1'b1)
   ) dut (
      .clk_50(clk_50), .reset_al(reset_al), .hdmi_int(hdmi_int), .lut_data(lut_data),
      .lut_index(lut_index), .config_done(config_done), .config_error(config_error),
      .retry_count(retry_count), .i2c(i2c_bus.master)
   );

   initial forever #10 clk_50 = ~clk_50;

   logic [15:0] lut_mem [64];
   assign lut_data = lut_mem[lut_index];

   int cyc = 0;
   initial forever begin
      @(posedge clk_50);
      cyc++;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int rel     = 0;

   // responder scripting and observed attempt log
   int fails_left [64];
   bit hang_mode  [64];
   int exp_fails  [64];
   int rise_q[$], fall_q[$], idx_q[$], retry_q[$];
   logic [7:0] b0_q[$], b1_q[$];

   // I2C master model: answers each request after a random latency, NACKs or hangs on scripted entries
   initial begin
      int  resp, hold;
      bit  nack_now, sp;
      resp = 0; hold = 0; nack_now = 0; sp = 0;
      i2c_bus.i2c_done = 1'b0;
      i2c_bus.i2c_fail = 1'b0;
      forever begin
         @(negedge clk_50);
         if (!reset_al) begin
            resp = 0; hold = 0; sp = 0;
            i2c_bus.i2c_done = 1'b0;
            i2c_bus.i2c_fail = 1'b0;
         end else begin
            if (i2c_bus.i2c_start && !sp) begin
               rise_q.push_back(cyc);
               idx_q.push_back(int'(lut_index));
               retry_q.push_back(int'(retry_count));
               b0_q.push_back(i2c_bus.i2c_byte0);
               b1_q.push_back(i2c_bus.i2c_byte1);
               nack_now = 1'b0;
               resp = int'($urandom_range(6, 2));
               if (fails_left[lut_index] > 0) begin
                  fails_left[lut_index]--;
                  if (hang_mode[lut_index]) resp = -1;
                  else                      nack_now = 1'b1;
               end
            end
            if (!i2c_bus.i2c_start && sp) fall_q.push_back(cyc);
            if (resp > 0) begin
               resp--;
               if (resp == 0) begin
                  i2c_bus.i2c_fail = nack_now;
                  i2c_bus.i2c_done = !(nack_now && ($urandom_range(1, 0) == 1));
                  hold = 3;
               end
            end else if (hold > 0) begin
               hold--;
               if (hold == 0) begin
                  i2c_bus.i2c_done = 1'b0;
                  i2c_bus.i2c_fail = 1'b0;
               end
            end
            sp = i2c_bus.i2c_start;
         end
      end
   end

   task automatic set_fails(input int idx, input int n, input bit hang);
      for (int i = 0; i < 64; i++) begin
         fails_left[i] = 0; exp_fails[i] = 0; hang_mode[i] = 1'b0;
      end
      if (idx >= 0) begin
         fails_left[idx] = n; exp_fails[idx] = n; hang_mode[idx] = hang;
      end
   endtask

   task automatic clear_log();
      rise_q.delete(); fall_q.delete(); idx_q.delete();
      retry_q.delete(); b0_q.delete(); b1_q.delete();
   endtask

   task automatic apply_reset();
      reset_al = 1'b0;
      repeat (3) @(negedge clk_50);
   endtask

   task automatic release_reset();
      clear_log();
      reset_al = 1'b1;
      rel = cyc;
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (!(config_done || config_error) && n < 6000) begin
         @(negedge clk_50);
         n++;
      end
      n_tests++;
      if (!(config_done || config_error)) begin
         n_fail++;
         $display("FAIL %s_finish: no done/error after %0d cycles, required one", name, n);
      end
   endtask

   // Reference: entry i fails its first exp_fails[i] attempts; more than MR retries ends the run in error
   task automatic check_seq(input string name);
      int  e_idx[$], e_rty[$];
      bit  e_err, bad;
      e_err = 1'b0;
      for (int i = 0; i < N && !e_err; i++) begin
         for (int a = 0; a <= MR; a++) begin
            e_idx.push_back(i);
            e_rty.push_back(a);
            if (a >= exp_fails[i]) break;
            if (a == MR) e_err = 1'b1;
         end
      end
      n_tests++;
      if (idx_q.size() != e_idx.size()) begin
         n_fail++;
         $display("FAIL %s_count: got %0d writes, required %0d", name, idx_q.size(), e_idx.size());
      end else begin
         for (int k = 0; k < e_idx.size(); k++) begin
            n_tests++;
            if (idx_q[k] != e_idx[k] || retry_q[k] != e_rty[k] ||
                b0_q[k] !== lut_mem[e_idx[k]][15:8] || b1_q[k] !== lut_mem[e_idx[k]][7:0]) begin
               n_fail++;
               $display("FAIL %s_write%0d: got idx %0d retry %0d bytes %h %h, required idx %0d retry %0d bytes %h",
                        name, k, idx_q[k], retry_q[k], b0_q[k], b1_q[k], e_idx[k], e_rty[k], lut_mem[e_idx[k]]);
               break;
            end
         end
      end
      n_tests++;
      if (config_error !== e_err || config_done !== !e_err) begin
         n_fail++;
         $display("FAIL %s_flags: got done %b error %b, required done %b error %b",
                  name, config_done, config_error, !e_err, e_err);
      end
      bad = 1'b0;
      for (int k = 1; k < rise_q.size() && k <= fall_q.size(); k++)
         if (rise_q[k] - fall_q[k-1] < G + 2) bad = 1'b1;
      n_tests++;
      if (bad || fall_q.size() < rise_q.size() - 1) begin
         n_fail++;
         $display("FAIL %s_gap: got start-low spacing below %0d cycles, required at least %0d", name, G + 2, G + 2);
      end
   endtask

   task automatic check_first_rise(input string name);
      n_tests++;
      if (rise_q.size() == 0 || rise_q[0] - rel != P + 2) begin
         n_fail++;
         $display("FAIL %s_first_start: got cycle %0d, required %0d", name,
                  (rise_q.size() == 0) ? -1 : rise_q[0] - rel, P + 2);
      end
   endtask

   task automatic test_reset();
      set_fails(-1, 0, 1'b0);
      apply_reset();
      n_tests++;
      if (i2c_bus.i2c_start !== 1'b0 || lut_index !== 6'd0 || config_done !== 1'b0 ||
          config_error !== 1'b0 || retry_count !== 2'd0 ||
          i2c_bus.i2c_byte0 !== 8'h00 || i2c_bus.i2c_byte1 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: got start %b idx %0d done %b err %b retry %0d bytes %h %h, required all zero",
                  i2c_bus.i2c_start, lut_index, config_done, config_error, retry_count,
                  i2c_bus.i2c_byte0, i2c_bus.i2c_byte1);
      end
      n_tests++;
      if (i2c_bus.i2c_slave_address !== 7'h72 || i2c_bus.i2c_byte_num !== 3'd2) begin
         n_fail++;
         $display("FAIL reset_consts: got addr %h num %0d, required 72 and 2",
                  i2c_bus.i2c_slave_address, i2c_bus.i2c_byte_num);
      end
   endtask

   task automatic test_all_ack();
      release_reset();
      wait_end("all_ack");
      check_first_rise("all_ack");
      check_seq("all_ack");
   endtask

   task automatic test_nack_retry();
      apply_reset();
      set_fails(5, 2, 1'b0);
      release_reset();
      wait_end("nack_retry");
      check_seq("nack_retry");
   endtask

   task automatic test_nack_exhaust();
      int  r0;
      bit  seen;
      apply_reset();
      set_fails(7, 100, 1'b0);
      release_reset();
      wait_end("nack_exhaust");
      check_seq("nack_exhaust");
      r0 = rise_q.size();
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk_50);
         if (i2c_bus.i2c_start !== 1'b0 || config_done !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen || rise_q.size() != r0 || config_error !== 1'b1) begin
         n_fail++;
         $display("FAIL err_terminal: got activity %b writes %0d error %b, required no activity, %0d writes, error 1",
                  seen, rise_q.size(), config_error, r0);
      end
   endtask

   task automatic test_timeout();
      int k;
      apply_reset();
      set_fails(3, 1, 1'b1);
      release_reset();
      wait_end("timeout");
      check_seq("timeout");
      k = 0;
      while (k < idx_q.size() && idx_q[k] != 3) k++;
      n_tests++;
      if (k >= fall_q.size() || fall_q[k] - rise_q[k] != T) begin
         n_fail++;
         $display("FAIL timeout_len: got start high %0d cycles, required %0d",
                  (k < fall_q.size()) ? fall_q[k] - rise_q[k] : -1, T);
      end
   endtask

   task automatic test_hotplug();
      int  p;
      bit  dropped;
      set_fails(-1, 0, 1'b0);
      clear_log();
      p = cyc;
      hdmi_int = 1'b1;
      dropped = 1'b0;
      for (int k = 0; k < 4 && !dropped; k++) begin
         @(negedge clk_50);
         if (k == 2) hdmi_int = 1'b0;
         if (config_done === 1'b0) dropped = 1'b1;
      end
      hdmi_int = 1'b0;
      n_tests++;
      if (!dropped) begin
         n_fail++;
         $display("FAIL hpd_drop: got config_done %b after 4 cycles, required 0", config_done);
      end
      wait_end("hotplug");
      check_seq("hotplug");
      n_tests++;
      if (rise_q.size() == 0 || rise_q[0] - p < P) begin
         n_fail++;
         $display("FAIL hpd_powerup: got first start %0d cycles after pulse, required at least %0d",
                  (rise_q.size() == 0) ? -1 : rise_q[0] - p, P);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset();
      set_fails(-1, 0, 1'b0);
      release_reset();
      n = 0;
      while (!(i2c_bus.i2c_start === 1'b1 && lut_index == 6'd10) && n < 3000) begin
         @(negedge clk_50);
         n++;
      end
      n_tests++;
      if (!(i2c_bus.i2c_start === 1'b1 && lut_index == 6'd10)) begin
         n_fail++;
         $display("FAIL midreset_reach: got idx %0d start %b, required idx 10 start 1", lut_index, i2c_bus.i2c_start);
      end
      reset_al = 1'b0;
      @(negedge clk_50);
      n_tests++;
      if (i2c_bus.i2c_start !== 1'b0 || lut_index !== 6'd0 || config_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: got start %b idx %0d done %b, required 0 0 0",
                  i2c_bus.i2c_start, lut_index, config_done);
      end
      @(negedge clk_50);
      release_reset();
      wait_end("midreset");
      check_first_rise("midreset");
      check_seq("midreset");
   endtask

   initial begin
      reset_al = 1'b0;
      hdmi_int = 1'b0;
      for (int i = 0; i < 64; i++) lut_mem[i] = 16'($urandom);
      test_reset();
      test_all_ack();
      test_nack_retry();
      test_nack_exhaust();
      test_timeout();
      test_hotplug();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
